regfile_mp: RTL and testbench

//  Parametrised multi-read-port, single-write-port register file for the ARM datapath.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_clear_fsm.sv | 65 ++++++
 rtl/regfile_mp.sv | 104 ++++++++++
 tb/tb_regfile_mp.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module : regfile_pkg
//  Shared types and helpers for the multi-port register file.
//  Rev    : 1.0  initial release
// ============================================================================
package regfile_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   // Default index of the hardwired zero register (XZR)
   localparam int XZR_IDX = 31;

   function automatic logic wr_accept(
      input logic idle,
      input logic en,
      input logic in_range,
      input logic is_zero
   );
      return idle && en && in_range && !is_zero;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
`default_nettype none
// ============================================================================
//  Module : regfile_clear_fsm
//  Post-reset / on-demand clearing sweep; owns state, sweep index and ready.
//  Rev    : 1.0  initial release
// ============================================================================
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int NREGS  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output state_t            state,
   output logic              ready,
   output logic              sweep_we,
   output logic [ADDR_W-1:0] sweep_addr
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

   logic [ADDR_W-1:0] idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         idx   <= '0;
         ready <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               if (clr_req) begin
                  idx <= '0;
               end else if (idx == LAST_IDX) begin
                  state <= IDLE;
                  ready <= 1'b1;
                  idx   <= '0;
               end else begin
                  idx <= idx + ADDR_W'(1);
               end
            end
            IDLE: begin
               if (clr_req) begin
                  state <= CLEAR;
                  idx   <= '0;
                  ready <= 1'b0;
               end
            end
            default: begin
               state <= CLEAR;
               idx   <= '0;
               ready <= 1'b0;
            end
         endcase
      end
   end

   // The sweep owns the array write port for every CLEAR cycle
   assign sweep_we   = (state == CLEAR);
   assign sweep_addr = idx;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module : regfile_mp
//  Multi-read, single-write register file with XZR and clearing sweep.
//  Option : define REGFILE_BYPASS_EN for same-cycle write-through on reads.
//  Rev    : 1.0  initial release
// ============================================================================
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int NREGS    = 32,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = XZR_IDX
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr_req,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     ready,
   output logic                     wr_drop
);

   localparam int               DEPTH     = 2 ** ADDR_W;
   localparam bit               ZERO_EN   = (ZERO_REG >= 0) && (ZERO_REG < NREGS);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ZERO_EN ? ADDR_W'(ZERO_REG) : '0;
   localparam logic [ADDR_W:0]   NREGS_EXT = (ADDR_W + 1)'(NREGS);

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < NREGS_EXT;
   endfunction

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return ZERO_EN && (a == ZERO_ADDR);
   endfunction

   state_t            state;
   logic              sweep_we;
   logic [ADDR_W-1:0] sweep_addr;
   logic              wr_ok;

   // Entries at or above NREGS are never written and never observed
   logic [DATA_W-1:0] mem [DEPTH];

   regfile_clear_fsm #(
      .ADDR_W (ADDR_W),
      .NREGS  (NREGS)
   ) u_clear_fsm (
      .clk        (clk),
      .rst        (rst),
      .clr_req    (clr_req),
      .state      (state),
      .ready      (ready),
      .sweep_we   (sweep_we),
      .sweep_addr (sweep_addr)
   );

   assign wr_ok = wr_accept(state == IDLE, wr_en, in_range(wr_addr), is_zero(wr_addr));

   always_ff @(posedge clk) begin
      if (sweep_we) begin
         mem[sweep_addr] <= '0;
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // A write to XZR is a legal no-op, so it is not reported as dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_drop <= 1'b0;
      end else begin
         wr_drop <= wr_en && ((state != IDLE) || !in_range(wr_addr));
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;

      assign addr = rd_addr[p*ADDR_W +: ADDR_W];

      always_comb begin
         data = mem[addr];
`ifdef REGFILE_BYPASS_EN
         if (wr_ok && (addr == wr_addr)) begin
            data = wr_data;
         end
`endif
         if (!ready || is_zero(addr) || !in_range(addr)) begin
            data = '0;
         end
      end

      assign rd_data[p*DATA_W +: DATA_W] = data;
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module : tb_regfile_mp
//  Scoreboard bench: 64b/32-reg/2-port instance and 32b/16-reg/3-port instance.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // instance a: defaults
   logic            clr_a = 1'b0, we_a = 1'b0;
   logic [AW-1:0]   wa_a  = '0;
   logic [63:0]     wd_a  = '0;
   logic [2*AW-1:0] ra_a  = '0;
   logic [127:0]    rd_a;
   logic            rdy_a, drop_a;

   // instance b: 32-bit, 16 regs, 3 ports, XZR disabled
   logic            clr_b = 1'b0, we_b = 1'b0;
   logic [AW-1:0]   wa_b  = '0;
   logic [31:0]     wd_b  = '0;
   logic [3*AW-1:0] ra_b  = '0;
   logic [95:0]     rd_b;
   logic            rdy_b, drop_b;

   regfile_mp u_dut_a (
      .clk (clk), .rst (rst), .clr_req (clr_a),
      .rd_addr (ra_a), .rd_data (rd_a),
      .wr_en (we_a), .wr_addr (wa_a), .wr_data (wd_a),
      .ready (rdy_a), .wr_drop (drop_a)
   );

   regfile_mp #(
      .DATA_W (32), .ADDR_W (AW), .NREGS (16), .NUM_RD (3), .ZERO_REG (31)
   ) u_dut_b (
      .clk (clk), .rst (rst), .clr_req (clr_b),
      .rd_addr (ra_b), .rd_data (rd_b),
      .wr_en (we_b), .wr_addr (wa_b), .wr_data (wd_b),
      .ready (rdy_b), .wr_drop (drop_b)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;
   exp_t sbq[$];

   logic [63:0] mod_a [32];
   logic [31:0] mod_b [16];
   bit          mrdy_a = 1'b0;
   bit          mrdy_b = 1'b0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] exp_a(input int a);
      if (!mrdy_a || a == 31 || a >= 32) return 64'h0;
      return mod_a[a];
   endfunction

   function automatic logic [63:0] exp_b(input int a);
      if (!mrdy_b || a >= 16) return 64'h0;
      return {32'h0, mod_b[a]};
   endfunction

   task automatic clear_models_a();
      for (int i = 0; i < 32; i++) mod_a[i] = 64'h0;
   endtask

   task automatic clear_models_b();
      for (int i = 0; i < 16; i++) mod_b[i] = 32'h0;
   endtask

   task automatic read_a_exp(input int a0, input int a1, input logic [63:0] e0,
                             input logic [63:0] e1);
      exp_t e;
      ra_a = {AW'(a1), AW'(a0)};
      sbq.push_back('{$sformatf("a_p0_r%0d", a0), e0});
      sbq.push_back('{$sformatf("a_p1_r%0d", a1), e1});
      #2;
      for (int p = 0; p < 2; p++) begin
         e = sbq.pop_front();
         check(e.tag, rd_a[p*64 +: 64], e.val);
      end
   endtask

   task automatic read_a(input int a0, input int a1);
      read_a_exp(a0, a1, exp_a(a0), exp_a(a1));
   endtask

   task automatic read_b(input int a0, input int a1, input int a2);
      exp_t e;
      ra_b = {AW'(a2), AW'(a1), AW'(a0)};
      sbq.push_back('{$sformatf("b_p0_r%0d", a0), exp_b(a0)});
      sbq.push_back('{$sformatf("b_p1_r%0d", a1), exp_b(a1)});
      sbq.push_back('{$sformatf("b_p2_r%0d", a2), exp_b(a2)});
      #2;
      for (int p = 0; p < 3; p++) begin
         e = sbq.pop_front();
         check(e.tag, {32'h0, rd_b[p*32 +: 32]}, e.val);
      end
   endtask

   task automatic wr_a(input int a, input logic [63:0] d);
      we_a = 1'b1; wa_a = AW'(a); wd_a = d;
      tick();
      we_a = 1'b0;
      if (mrdy_a && a < 32 && a != 31) mod_a[a] = d;
   endtask

   task automatic wr_b(input int a, input logic [31:0] d);
      we_b = 1'b1; wa_b = AW'(a); wd_b = d;
      tick();
      we_b = 1'b0;
      if (mrdy_b && a < 16) mod_b[a] = d;
   endtask

   // Counts negedges on which each instance is still not ready
   task automatic wait_ready(output int na, output int nb);
      na = 0;
      nb = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (rdy_a && rdy_b) break;
         if (!rdy_a) na++;
         if (!rdy_b) nb++;
      end
      tick();
   endtask

   initial begin
      int na, nb;
      logic [63:0] e;

      clear_models_a();
      clear_models_b();

      // reset state
      #12;
      check("rst_ready_a", {63'h0, rdy_a}, 64'h0);
      check("rst_drop_a", {63'h0, drop_a}, 64'h0);
      check("rst_ready_b", {63'h0, rdy_b}, 64'h0);
      read_a(0, 5);
      tick();
      rst = 1'b0;
      wait_ready(na, nb);
      check("sweep_len_a", 64'(na), 64'd32);
      check("sweep_len_b", 64'(nb), 64'd16);
      mrdy_a = 1'b1;
      mrdy_b = 1'b1;

      for (int a = 0; a < 32; a++) read_a(a, 31 - a);
      read_b(0, 15, 20);

      // basic write / dual-port read
      wr_a(5, 64'hDEAD_BEEF_0000_0001);
      check("drop_w5", {63'h0, drop_a}, 64'h0);
      read_a(5, 5);

      // zero register
      wr_a(31, 64'h1234);
      check("drop_xzr", {63'h0, drop_a}, 64'h0);
      read_a(31, 5);

      // out-of-range write on the 16-entry instance
      wr_b(31, 32'h1234);
      check("drop_oor_b", {63'h0, drop_b}, 64'h1);
      tick();
      check("drop_pulse_b", {63'h0, drop_b}, 64'h0);
      wr_b(15, 32'hCAFE);
      read_b(15, 31, 0);

      // same-cycle write and read
      wr_a(7, 64'h55);
      we_a = 1'b1; wa_a = AW'(7); wd_a = 64'hAA;
      e = BYPASS ? 64'hAA : 64'h55;
      read_a_exp(7, 7, e, e);
      tick();
      we_a = 1'b0;
      mod_a[7] = 64'hAA;
      read_a(7, 7);

      // clr_req with a simultaneous write, then a write during the sweep
      wr_a(3, 64'h77);
      clr_a = 1'b1; we_a = 1'b1; wa_a = AW'(4); wd_a = 64'h44;
      tick();
      clr_a = 1'b0; we_a = 1'b0;
      check("clr_ready_drop_a", {63'h0, rdy_a}, 64'h0);
      check("clr_wr_nodrop_a", {63'h0, drop_a}, 64'h0);
      mrdy_a = 1'b0;
      clear_models_a();
      na = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (rdy_a) break;
         na++;
         if (na == 5) begin
            we_a = 1'b1; wa_a = AW'(1); wd_a = 64'h99;
         end else if (na == 6) begin
            we_a = 1'b0;
            check("sweep_wr_drop_a", {63'h0, drop_a}, 64'h1);
         end
      end
      check("clr_sweep_len_a", 64'(na), 64'd32);
      tick();
      mrdy_a = 1'b1;
      read_a(3, 4);
      read_a(1, 7);

      // reset in the middle of the sweep
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mrdy_a = 1'b0;
      mrdy_b = 1'b0;
      clear_models_a();
      clear_models_b();
      repeat (10) tick();
      check("mid_sweep_ready_a", {63'h0, rdy_a}, 64'h0);
      rst = 1'b1;
      #1;
      check("mid_rst_ready_a", {63'h0, rdy_a}, 64'h0);
      tick();
      rst = 1'b0;
      wait_ready(na, nb);
      check("restart_len_a", 64'(na), 64'd32);
      check("restart_len_b", 64'(nb), 64'd16);
      mrdy_a = 1'b1;
      mrdy_b = 1'b1;
      read_a(5, 7);

      // three-port instance: writes, clr_req, full clear
      wr_b(1, 32'h11);
      wr_b(2, 32'h22);
      wr_b(9, 32'h99);
      read_b(1, 2, 9);
      read_b(9, 9, 9);
      clr_b = 1'b1;
      tick();
      clr_b = 1'b0;
      check("clr_ready_drop_b", {63'h0, rdy_b}, 64'h0);
      mrdy_b = 1'b0;
      clear_models_b();
      wait_ready(na, nb);
      check("clr_sweep_len_b", 64'(nb), 64'd16);
      mrdy_b = 1'b1;
      for (int a = 0; a < 16; a++) read_b(a, 15 - a, (a + 3) % 16);

      check("sb_empty", 64'(sbq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
